// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fft_pkg
// Description : Shared constants and helpers for the FFT input buffer.
//               - sample_width : word width derived from the sample MSB index
//               - log2n_of     : index width derived from the frame length
//               - bitrev       : reverses the low log2n bits of a frame index
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int Q_IN_DEFAULT = 15;
  localparam int N_DEFAULT    = 8;
  localparam int MAX_LOG2N    = 4;   // frames up to 16 samples; addr_out is 4 bits

  function automatic int sample_width(input int q_in);
    return q_in + 1;
  endfunction

  // Ceiling log2, bounded to the supported frame range.
  function automatic int log2n_of(input int n);
    int r;
    r = 0;
    for (int i = 0; i <= MAX_LOG2N; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Bits above log2n are returned as zero.
  function automatic logic [3:0] bitrev(input logic [3:0] idx, input int log2n);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOG2N; i++) begin
      if (i < log2n) r[i] = idx[log2n-1-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : fft_bank_ram
// Description : Simple dual-port RAM holding both ping-pong banks.
//               Address = {bank, idx}. One synchronous write port and one
//               synchronous read port; the registered read gives the one-cycle
//               request-to-data latency. Only the read register is reset,
//               the storage array is not.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               wr_en/wr_addr/wr_data - write port
//               rd_en/rd_addr         - read strobe and address
//               rd_data               - registered read data, holds when idle
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bank_ram #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fft_input_buffer
// Description : Ping-pong frame buffer feeding the first FFT stage. Collects
//               complex samples into N-sample frames and returns them one per
//               request in bit-reversed order with one cycle of latency.
// Ports       : clk, reset                 - clock, sync active-high reset
//               sample_valid/real/imag     - input sample stream
//               sample_ready               - write bank has space
//               valid_packet               - read bank holds a full frame
//               valid_request              - request next sample
//               valid_out, data_out_*,     - returned sample, its natural index
//               addr_out
//               drop_err, req_err          - sticky protocol error flags
// Revision    : 1.0 - initial release
// ============================================================================
module fft_input_buffer
  import fft_pkg::*;
#(
  parameter int Q_IN = Q_IN_DEFAULT,
  parameter int N    = N_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic signed [Q_IN:0] sample_real,
  input  logic signed [Q_IN:0] sample_imag,
  output logic               sample_ready,
  output logic               valid_packet,
  input  logic               valid_request,
  output logic               valid_out,
  output logic signed [Q_IN:0] data_out_real,
  output logic signed [Q_IN:0] data_out_imag,
  output logic [3:0]         addr_out,
  output logic               drop_err,
  output logic               req_err
);

  localparam int LOG2N = log2n_of(N);
  localparam int W     = sample_width(Q_IN);
  localparam int AW    = LOG2N + 1;

  localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] IDX_ONE  = LOG2N'(1);

  logic             wr_bank;
  logic             rd_bank;
  logic [LOG2N-1:0] wr_idx;
  logic [LOG2N-1:0] rd_idx;
  logic [1:0]       full;
  logic [1:0]       full_next;

  logic             wr_fire;
  logic             rd_fire;
  logic             wr_last;
  logic             rd_last;
  logic [3:0]       rd_idx_ext;
  logic [3:0]       rd_rev;
  logic [2*W-1:0]   rd_word;

  // Both flags come straight from registered state, so neither has a
  // combinational path from any input.
  assign sample_ready = !full[wr_bank];
  assign valid_packet = full[rd_bank];

  assign wr_fire = sample_valid & sample_ready;
  assign rd_fire = valid_request & valid_packet;
  assign wr_last = wr_fire && (wr_idx == IDX_LAST);
  assign rd_last = rd_fire && (rd_idx == IDX_LAST);

  assign rd_idx_ext = 4'(rd_idx);
  assign rd_rev     = bitrev(rd_idx_ext, LOG2N);

  // The writer can only be in a non-full bank and the reader only in a full
  // one, so the two updates always hit different bits.
  always_comb begin
    full_next = full;
    if (wr_last) full_next[wr_bank] = 1'b1;
    if (rd_last) full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
      rd_bank   <= 1'b0;
      rd_idx    <= '0;
      full      <= 2'b00;
      valid_out <= 1'b0;
      addr_out  <= 4'h0;
      drop_err  <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_last) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx  <= wr_idx + IDX_ONE;
        end
      end

      if (rd_fire) begin
        if (rd_last) begin
          rd_idx  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_idx  <= rd_idx + IDX_ONE;
        end
        addr_out <= rd_rev;
      end

      full      <= full_next;
      valid_out <= rd_fire;

      if (sample_valid & !sample_ready)  drop_err <= 1'b1;
      if (valid_request & !valid_packet) req_err  <= 1'b1;
    end
  end

  fft_bank_ram #(
    .DW (2 * W),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_fire),
    .wr_addr ({wr_bank, wr_idx}),
    .wr_data ({sample_real, sample_imag}),
    .rd_en   (rd_fire),
    .rd_addr ({rd_bank, rd_rev[LOG2N-1:0]}),
    .rd_data (rd_word)
  );

  // The RAM read register only loads on an accepted request, which gives
  // the hold-when-idle behaviour of the data outputs.
  assign data_out_real = rd_word[2*W-1:W];
  assign data_out_imag = rd_word[W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fft_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_input_buffer
// Description : Self-checking bench for fft_input_buffer (Q_IN=15, N=8).
//               Reference model: a queue of completed frames, a partial
//               frame and a read position within the oldest frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_input_buffer;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_valid = 1'b0;
  logic        valid_request = 1'b0;
  logic [15:0] sample_real = '0;
  logic [15:0] sample_imag = '0;
  logic        sample_ready;
  logic        valid_packet;
  logic        valid_out;
  logic [15:0] data_out_real;
  logic [15:0] data_out_imag;
  logic [3:0]  addr_out;
  logic        drop_err;
  logic        req_err;

  fft_input_buffer #(.Q_IN(15), .N(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .sample_real   (sample_real),
    .sample_imag   (sample_imag),
    .sample_ready  (sample_ready),
    .valid_packet  (valid_packet),
    .valid_request (valid_request),
    .valid_out     (valid_out),
    .data_out_real (data_out_real),
    .data_out_imag (data_out_imag),
    .addr_out      (addr_out),
    .drop_err      (drop_err),
    .req_err       (req_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Bit-reversal of a 3-bit index by plain arithmetic.
  function automatic int brev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] fq[$];     // completed frames, oldest first
  logic [31:0] part[$];   // frame being collected
  int          pos;       // next read position in oldest frame
  logic        m_vo;
  logic [15:0] m_re, m_im;
  logic [3:0]  m_addr;
  logic        m_drop, m_req;

  function automatic bit m_ready();
    return fq.size() < 2 * N;
  endfunction

  function automatic bit m_vp();
    return fq.size() >= N;
  endfunction

  task automatic m_reset();
    fq.delete();
    part.delete();
    pos = 0;
    m_vo = 0; m_re = '0; m_im = '0; m_addr = '0; m_drop = 0; m_req = 0;
  endtask

  task automatic m_step(input bit sv, input logic [31:0] s, input bit vr);
    bit rdy, vp;
    int a;
    rdy = m_ready();
    vp  = m_vp();
    m_vo = 0;
    if (vr) begin
      if (vp) begin
        a = brev3(pos);
        m_vo = 1;
        {m_re, m_im} = fq[a];
        m_addr = 4'(a);
        pos++;
        if (pos == N) begin
          for (int i = 0; i < N; i++) void'(fq.pop_front());
          pos = 0;
        end
      end else begin
        m_req = 1;
      end
    end
    if (sv) begin
      if (rdy) begin
        part.push_back(s);
        if (part.size() == N) begin
          foreach (part[i]) fq.push_back(part[i]);
          part.delete();
        end
      end else begin
        m_drop = 1;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic chk_regs();
    chk("valid_out", valid_out, m_vo);
    chk("data_out_real", data_out_real, m_re);
    chk("data_out_imag", data_out_imag, m_im);
    chk("addr_out", addr_out, m_addr);
    chk("drop_err", drop_err, m_drop);
    chk("req_err", req_err, m_req);
  endtask

  // Called at a negedge: drive, check state-derived flags, advance one edge.
  task automatic cyc(input bit sv, input logic [15:0] re, input logic [15:0] im, input bit vr);
    sample_valid  = sv;
    sample_real   = re;
    sample_imag   = im;
    valid_request = vr;
    chk("sample_ready", sample_ready, m_ready());
    chk("valid_packet", valid_packet, m_vp());
    m_step(sv, {re, im}, vr);
    @(posedge clk);
    @(negedge clk);
    sample_valid  = 0;
    valid_request = 0;
    chk_regs();
  endtask

  task automatic wr(input int v);
    cyc(1'b1, 16'(v), 16'(-v), 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 16'h0, 16'h0, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1;
    sample_valid = 0;
    valid_request = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    m_reset();
    chk_regs();
    chk("reset_ready", sample_ready, 1);
    chk("reset_vp", valid_packet, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          sv;
    bit          vr;
    logic [15:0] re;
    bit          exp_vo;
    bit          exp_vp;
    logic [15:0] exp_re;
    logic [3:0]  exp_addr;
  } vec_t;

  vec_t tbl[24];

  initial begin
    int n;
    int pulses;

    n = 0;
    for (int k = 0; k < 8; k++) begin
      tbl[n] = '{1'b1, 1'b0, 16'(k), 1'b0, (k == 7), 16'h0, 4'h0};
      n++;
    end
    for (int j = 0; j < 8; j++) begin
      tbl[n] = '{1'b0, 1'b1, 16'h0, 1'b1, (j != 7), 16'(brev3(j)), 4'(brev3(j))};
      n++;
      tbl[n] = '{1'b0, 1'b0, 16'h0, 1'b0, (j != 7), 16'(brev3(j)), 4'(brev3(j))};
      n++;
    end

    @(negedge clk);
    do_reset();

    // Frame re=k, im=-k, spaced requests.
    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].sv, tbl[i].re, 16'h0 - tbl[i].re, tbl[i].vr);
      chk("tbl_vo", valid_out, tbl[i].exp_vo);
      chk("tbl_vp", valid_packet, tbl[i].exp_vp);
      chk("tbl_re", data_out_real, tbl[i].exp_re);
      chk("tbl_addr", addr_out, tbl[i].exp_addr);
    end

    // Back-to-back requests.
    for (int k = 0; k < 8; k++) wr(20 + k);
    pulses = 0;
    for (int j = 0; j < 8; j++) begin
      rd();
      if (valid_out) pulses++;
    end
    chk("b2b_pulses", pulses, 8);

    // Both banks full, overflow, then release.
    for (int k = 0; k < 16; k++) wr(30 + k);
    chk("ready_after_16", sample_ready, 0);
    wr(99);
    chk("drop_err_set", drop_err, 1);
    for (int j = 0; j < 8; j++) rd();
    chk("ready_after_drain", sample_ready, 1);
    chk("vp_frame2", valid_packet, 1);
    for (int j = 0; j < 8; j++) rd();
    chk("vp_empty", valid_packet, 0);

    // Request with no frame.
    rd();
    chk("noframe_vo", valid_out, 0);
    chk("noframe_req_err", req_err, 1);
    for (int k = 0; k < 8; k++) wr(50 + k);
    rd();
    chk("noframe_first_addr", addr_out, 0);
    chk("noframe_first_re", data_out_real, 50);
    for (int j = 1; j < 8; j++) rd();

    // Last write of frame 2 coincides with last read of frame 1.
    do_reset();
    for (int k = 0; k < 8; k++) wr(60 + k);
    for (int j = 0; j < 7; j++) cyc(1'b1, 16'(70 + j), 16'(-(70 + j)), 1'b1);
    cyc(1'b1, 16'(77), 16'(-77), 1'b1);
    chk("coinc_vp", valid_packet, 1);
    chk("coinc_last_re", data_out_real, 67);
    chk("coinc_last_addr", addr_out, 7);
    rd();
    chk("coinc_f2_first_re", data_out_real, 70);
    for (int j = 1; j < 8; j++) rd();

    // Reset mid-frame with a partially read frame.
    for (int k = 0; k < 8; k++) wr(80 + k);
    rd();
    rd();
    for (int k = 0; k < 5; k++) wr(90 + k);
    do_reset();
    chk("rst_vo", valid_out, 0);
    chk("rst_re", data_out_real, 0);
    chk("rst_drop", drop_err, 0);
    chk("rst_req", req_err, 0);
    for (int k = 0; k < 8; k++) wr(100 + k);
    rd();
    chk("rst_first_addr", addr_out, 0);
    chk("rst_first_re", data_out_real, 100);
    for (int j = 1; j < 8; j++) rd();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
